// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// One transaction at a time: grant/latch operands, capture result, hold until accepted.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_x,
  input  logic [W*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      alu_x,
  output logic [W-1:0]      alu_y,
  output logic [2:0]        alu_opcod,
  output logic              alu_cin,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_out,
  output logic              rsp_cout,
  input  logic              rsp_ready
);

  // state | meaning
  // IDLE  | waiting for any req; winner latched at the edge that leaves IDLE
  // EXEC  | operands drive the ALU; result captured at the edge that leaves EXEC
  // RESP  | result held on the response channel until rsp_valid && rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;

  // Search ptr+1 .. ptr+NREQ; walking backwards lets the nearest set bit win.
  always_comb begin
    win  = ptr;
    cand = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (req[cand]) win = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_opcod <= '0;
      alu_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= '0;
      rsp_cout  <= 1'b0;
      ptr       <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= NREQ'(1) << win;
            alu_x     <= req_x[int'(win)*W +: W];
            alu_y     <= req_y[int'(win)*W +: W];
            alu_opcod <= req_op[int'(win)*3 +: 3];
            alu_cin   <= req_cin[win];
            rsp_id    <= win;
            ptr       <= win;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_cout  <= alu_cout;
          rsp_valid <= 1'b1;
          gnt       <= '0;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the reset, single-op, backpressure and round-robin cases.
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [3*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_x = '0;
  logic [W*NREQ-1:0] req_y = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      alu_x, alu_y, alu_out;
  logic [2:0]        alu_opcod;
  logic              alu_cin, alu_cout;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_out;
  logic              rsp_cout;
  logic              rsp_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  int cyc_n  = 0;
  int gnt_idx[$];
  int gnt_cyc[$];

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .req_cin(req_cin), .gnt(gnt), .alu_x(alu_x), .alu_y(alu_y), .alu_opcod(alu_opcod),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_cout(rsp_cout), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] x,
                                         input logic [15:0] y, input logic cin);
    case (op)
      3'd0: alu_fn = {1'b0, x} + {1'b0, y} + {16'b0, cin};
      3'd1: alu_fn = {1'b0, x} - {1'b0, y} - {16'b0, cin};
      3'd2: alu_fn = {1'b0, x & y};
      3'd3: alu_fn = {1'b0, x | y};
      3'd4: alu_fn = {1'b0, x ^ y};
      3'd5: alu_fn = {1'b0, ~x};
      3'd6: alu_fn = {x, 1'b0};
      default: alu_fn = {1'b0, x};
    endcase
  endfunction

  always_comb {alu_cout, alu_out} = alu_fn(alu_opcod, alu_x, alu_y, alu_cin);

  function automatic int rr_pick(input int p, input logic [3:0] r);
    logic [3:0] sh;
    for (int s = 1; s <= NREQ; s++) begin
      sh = r >> ((p + s) % NREQ);
      if (sh[0]) return (p + s) % NREQ;
    end
    return -1;
  endfunction

  // Transaction model: a grant occupies the ALU for one cycle, then the result
  // sits on the response channel until accepted.
  int          m_ptr;
  bit          m_busy;
  logic [3:0]  m_gnt;
  logic [15:0] m_x, m_y, m_out;
  logic [2:0]  m_op;
  logic        m_cin, m_valid, m_cout;
  logic [1:0]  m_id;
  logic [16:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= NREQ - 1; m_busy <= 1'b0; m_gnt <= '0;
      m_x <= '0; m_y <= '0; m_op <= '0; m_cin <= 1'b0;
      m_valid <= 1'b0; m_id <= '0; m_out <= '0; m_cout <= 1'b0; m_res <= '0;
    end else if (!m_busy) begin
      if (req != 0) begin
        int k;
        k = rr_pick(m_ptr, req);
        m_gnt  <= 4'(1 << k);
        m_x    <= req_x[k*W +: W];
        m_y    <= req_y[k*W +: W];
        m_op   <= req_op[k*3 +: 3];
        m_cin  <= req_cin[k];
        m_id   <= 2'(k);
        m_ptr  <= k;
        m_res  <= alu_fn(req_op[k*3 +: 3], req_x[k*W +: W], req_y[k*W +: W], req_cin[k]);
        m_busy <= 1'b1;
      end
    end else if (m_gnt != 0) begin
      m_gnt <= '0;
      m_valid <= 1'b1;
      {m_cout, m_out} <= m_res;
    end else if (m_valid && rsp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gnt", 32'(gnt), 32'(m_gnt));
      check("m_alu_x", 32'(alu_x), 32'(m_x));
      check("m_alu_y", 32'(alu_y), 32'(m_y));
      check("m_alu_opcod", 32'(alu_opcod), 32'(m_op));
      check("m_alu_cin", 32'(alu_cin), 32'(m_cin));
      check("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("m_rsp_id", 32'(rsp_id), 32'(m_id));
      check("m_rsp_out", 32'(rsp_out), 32'(m_out));
      check("m_rsp_cout", 32'(rsp_cout), 32'(m_cout));
    end
    if (log_en && gnt != 0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_idx.push_back(i);
      gnt_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    req_x = {4{16'h1234}};
    req_y = {4{16'h0101}};
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;

    // reset asserted mid-EXEC
    req = 4'b1111;
    cyc(1);
    #2 rst = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_alu_x", 32'(alu_x), 32'h0);
    check("rst_alu_y", 32'(alu_y), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("rst_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    cyc(3);

    // single op: FFFF + 0001 carries out
    req_op[8:6] = 3'd0; req_x[32 +: 16] = 16'hFFFF; req_y[32 +: 16] = 16'h0001; req_cin[2] = 1'b0;
    req = 4'b0100;
    cyc(1);
    check("single_gnt", 32'(gnt), 32'h4);
    req = '0;
    cyc(1);
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id", 32'(rsp_id), 32'h2);
    check("single_out", 32'(rsp_out), 32'h0000);
    check("single_cout", 32'(rsp_cout), 32'h1);
    cyc(1);
    check("single_done", 32'(rsp_valid), 32'h0);

    // backpressure: result must hold while rsp_ready is low
    req_op[5:3] = 3'd2; req_x[16 +: 16] = 16'hF0F0; req_y[16 +: 16] = 16'hFF00; req_cin[1] = 1'b0;
    rsp_ready = 1'b0;
    req = 4'b0010;
    cyc(1);
    check("bp_gnt", 32'(gnt), 32'h2);
    req = 4'b0001;
    cyc(1);
    repeat (5) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_out", 32'(rsp_out), 32'hF000);
      check("bp_no_gnt", 32'(gnt), 32'h0);
      cyc(1);
    end
    req = '0;
    rsp_ready = 1'b1;
    cyc(1);
    check("bp_release", 32'(rsp_valid), 32'h0);

    // operand change during EXEC must not affect the latched result
    req_op[5:3] = 3'd3; req_x[16 +: 16] = 16'h00F0; req_y[16 +: 16] = 16'h0F00;
    req = 4'b0010;
    cyc(1);
    check("chg_gnt", 32'(gnt), 32'h2);
    req_x[16 +: 16] = 16'hFFFF;
    req = '0;
    cyc(1);
    check("chg_out", 32'(rsp_out), 32'h0FF0);
    cyc(1);

    // reset while a response is pending
    req_op[2:0] = 3'd4; req_x[0 +: 16] = 16'hAAAA; req_y[0 +: 16] = 16'h5555;
    rsp_ready = 1'b0;
    req = 4'b0001;
    cyc(1);
    req = '0;
    cyc(1);
    check("rresp_valid", 32'(rsp_valid), 32'h1);
    check("rresp_out", 32'(rsp_out), 32'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("rresp_drop", 32'(rsp_valid), 32'h0);
    cyc(1);
    rst = 1'b0;
    req_op[11:9] = 3'd0; req_x[48 +: 16] = 16'h0001; req_y[48 +: 16] = 16'h0002; req_cin[3] = 1'b1;
    req = 4'b1000;
    cyc(1);
    check("rresp_gnt", 32'(gnt), 32'h8);
    req = '0;
    rsp_ready = 1'b1;
    cyc(1);
    check("rresp_sum", 32'(rsp_out), 32'h0004);
    cyc(2);

    // round-robin with requesters 0,1,3 held high
    log_en = 1'b1;
    req = 4'b1011;
    cyc(18);
    req = '0;
    cyc(3);
    log_en = 1'b0;
    check("rr_count", 32'(gnt_idx.size()), 32'd6);
    if (gnt_idx.size() == 6 && gnt_cyc.size() == 6) begin
      int exp_order[6];
      exp_order = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 6; i++) check("rr_order", 32'(gnt_idx[i]), 32'(exp_order[i]));
      for (int i = 1; i < 6; i++) check("rr_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
